uart_tx_arbiter: RTL and testbench

//  Shares one CoreUART transmitter among NUM_REQ byte-stream requesters.
//  - Round-robin arbitration; the grant is held for a whole packet, up to and including the byte flagged last.
//  - Sequences the UART host strobes (CSN/WEN/DATA_IN) against TXRDY.
//  - Sits between on-chip message sources and the UART core; no reads of the UART are issued.

---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/uart_rr_picker.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared constants and types for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

  localparam int unsigned GRANT_W            = 3;
  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STROBE = 2'd2,
    ST_SETTLE = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } tx_byte_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request after last_grant, wrapping modulo NUM_REQ.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               found_c,
  output logic [GRANT_W-1:0] idx_c
);

  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found_c && req[i] && (i == (32'(last_grant) + off) % NUM_REQ)) begin
          found_c = 1'b1;
          idx_c   = GRANT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one CoreUART transmitter among NUM_REQ packet requesters with round-robin grants.
// Optional mid-packet idle timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      TXRDY,
  output logic                      CSN,
  output logic                      WEN,
  output logic [BYTE_W-1:0]         DATA_IN,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy,
  output logic                      timeout_abort
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] last_grant_q, last_grant_d;
  tx_byte_t           byte_q, byte_d;
  logic               strobe_n_q, strobe_n_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pick_found_c;
  logic [GRANT_W-1:0] pick_idx_c;
  logic               sel_valid_c;
  tx_byte_t           sel_byte_c;
  logic               accept_c;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            started_q, started_d;
  logic            abort_q, abort_d;
`endif

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .found_c    (pick_found_c),
    .idx_c      (pick_idx_c)
  );

  // Route the granted requester's handshake and byte.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_byte_c  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        sel_valid_c     = req_valid[i];
        sel_byte_c.last = req_last[i];
        sel_byte_c.data = req_data[BYTE_W*i +: BYTE_W];
      end
    end
  end

  assign accept_c = (state_q == ST_WAIT) && sel_valid_c && TXRDY;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GRANT_W'(i)) req_ready[i] = accept_c;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    byte_d       = byte_q;
    strobe_n_d   = 1'b1;
    busy_d       = busy_q;
    cnt_d        = cnt_q;
`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    started_d    = started_q;
    abort_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
        to_cnt_d  = '0;
        started_d = 1'b0;
`endif
        if (pick_found_c) begin
          grant_d = pick_idx_c;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Strobe is registered so CSN/WEN go low exactly while in STROBE.
        if (accept_c) begin
          byte_d     = sel_byte_c;
          strobe_n_d = 1'b0;
          state_d    = ST_STROBE;
`ifdef UART_ARB_TIMEOUT_EN
          started_d  = 1'b1;
          to_cnt_d   = '0;
`endif
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (started_q && !sel_valid_c) begin
          if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            abort_d      = 1'b1;
            last_grant_d = grant_q;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
`endif
      end
      ST_STROBE: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          if (byte_q.last) begin
            last_grant_d = grant_q;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(NUM_REQ - 1);
      byte_q       <= '0;
      strobe_n_q   <= 1'b1;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      started_q    <= 1'b0;
      abort_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      byte_q       <= byte_d;
      strobe_n_q   <= strobe_n_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      started_q    <= started_d;
      abort_q      <= abort_d;
`endif
    end
  end

  assign CSN      = strobe_n_q;
  assign WEN      = strobe_n_q;
  assign DATA_IN  = byte_q.data;
  assign grant_id = grant_q;
  assign busy     = busy_q;

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_abort = abort_q;
`else
  assign timeout_abort = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: packet sources, a UART TXRDY model and a round-robin packet model.
module tb_uart_tx_arbiter;

  localparam int NREQ   = 4;
  localparam int SETTLE = 2;
  localparam int TMO    = 16;

  logic              CLK;
  logic              RESET_N;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              TXRDY;
  logic              CSN;
  logic              WEN;
  logic [7:0]        DATA_IN;
  logic [2:0]        grant_id;
  logic              busy;
  logic              timeout_abort;

  uart_tx_arbiter #(
    .NUM_REQ        (NREQ),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .TXRDY         (TXRDY),
    .CSN           (CSN),
    .WEN           (WEN),
    .DATA_IN       (DATA_IN),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_abort (timeout_abort)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { int idle; int req; logic [7:0] data; int cyc; } ev_t;
  typedef struct { int req; logic [7:0] data; bit first; } exp_t;

  logic [8:0] src_q [NREQ][$];
  logic [8:0] mdl_q [NREQ][$];
  ev_t        log_q [$];
  exp_t       exp_q [$];

  int cmp_cnt, err_cnt, viol_cnt, ready_cnt, abort_cnt, abort_cyc;
  int cyc, idle_cnt, uart_cnt, model_last;
  bit abort_busy, txrdy_en, prev_low;
  logic [NREQ-1:0] ready_s;

  // Sources, UART model and strobe monitor: sample at negedge, drive just after posedge.
  always begin
    ev_t ev;
    @(negedge CLK);
    cyc++;
    ready_s = req_ready;
    if (CSN !== WEN) viol_cnt++;
    if (CSN === 1'b0 && (prev_low || busy !== 1'b1)) viol_cnt++;
    prev_low = (CSN === 1'b0);
    if (req_ready !== '0) begin
      ready_cnt++;
      if (req_ready !== (NREQ'(1) << grant_id) || TXRDY !== 1'b1 || (req_ready & req_valid) === '0)
        viol_cnt++;
    end
    if (CSN === 1'b0) begin
      ev.idle = idle_cnt; ev.req = int'(grant_id); ev.data = DATA_IN; ev.cyc = cyc;
      log_q.push_back(ev);
      idle_cnt = 0;
      uart_cnt = 10;
    end
    if (busy === 1'b0) idle_cnt++;
    if (timeout_abort === 1'b1) begin
      abort_cnt++; abort_cyc = cyc; abort_busy = busy;
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (ready_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (uart_cnt > 0) uart_cnt--;
    TXRDY = txrdy_en && (uart_cnt == 0);
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_q[i][0][7:0];
        req_last[i]        = src_q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_byte(input int r, input logic [7:0] d, input bit last, input bit to_model);
    src_q[r].push_back({last, d});
    if (to_model) mdl_q[r].push_back({last, d});
  endtask

  task automatic push_pkt(input int r, input int len);
    for (int j = 0; j < len; j++) push_byte(r, 8'($urandom), (j == len - 1), 1'b1);
  endtask

  // Reference: whole packets served round-robin from the requester after the last one served.
  task automatic model_drain();
    int pick;
    logic [8:0] b;
    bit first;
    exp_t e;
    while (1) begin
      pick = -1;
      for (int off = 1; off <= NREQ; off++)
        if (pick < 0 && mdl_q[(model_last + off) % NREQ].size() > 0) pick = (model_last + off) % NREQ;
      if (pick < 0) break;
      first = 1'b1;
      do begin
        b = mdl_q[pick].pop_front();
        e.req = pick; e.data = b[7:0]; e.first = first;
        exp_q.push_back(e);
        first = 1'b0;
      end while (!b[8] && mdl_q[pick].size() > 0);
      model_last = pick;
    end
  endtask

  task automatic check_log(input string name);
    int k;
    k = 0;
    while (k < 4000 && !(log_q.size() >= exp_q.size() && busy === 1'b0 && src_empty())) begin
      tick(); k++;
    end
    repeat (14) tick();
    cmp_cnt++;
    if (k >= 4000) begin
      err_cnt++; $display("FAIL %s_done: wait expired after %0d cycles, required completion", name, k);
    end
    cmp_cnt++;
    if (log_q.size() != exp_q.size()) begin
      err_cnt++; $display("FAIL %s_count: got %0d strobes, required %0d", name, log_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
      cmp_cnt++;
      if (log_q[j].req != exp_q[j].req || log_q[j].data !== exp_q[j].data) begin
        err_cnt++;
        $display("FAIL %s_byte%0d: got req%0d 0x%02h, required req%0d 0x%02h", name, j,
                 log_q[j].req, log_q[j].data, exp_q[j].req, exp_q[j].data);
      end
      if (j > 0) begin
        cmp_cnt++;
        if (log_q[j].idle != (exp_q[j].first ? 1 : 0)) begin
          err_cnt++;
          $display("FAIL %s_gap%0d: got %0d idle cycles, required %0d", name, j, log_q[j].idle,
                   exp_q[j].first ? 1 : 0);
        end
      end
    end
    cmp_cnt++;
    if (viol_cnt != 0) begin
      err_cnt++; $display("FAIL %s_protocol: got %0d strobe/ready violations, required 0", name, viol_cnt);
      viol_cnt = 0;
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    for (int i = 0; i < NREQ; i++) begin src_q[i].delete(); mdl_q[i].delete(); end
    repeat (3) tick();
    log_q.delete();
    uart_cnt   = 0;
    model_last = NREQ - 1;
    RESET_N    = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    int k;
    repeat (3) tick();
    cmp_cnt++; if (CSN !== 1'b1) begin err_cnt++; $display("FAIL rst_csn: got %b required 1", CSN); end
    cmp_cnt++; if (WEN !== 1'b1) begin err_cnt++; $display("FAIL rst_wen: got %b required 1", WEN); end
    cmp_cnt++; if (DATA_IN !== 8'h00) begin err_cnt++; $display("FAIL rst_data: got %h required 00", DATA_IN); end
    cmp_cnt++; if (grant_id !== 3'd0) begin err_cnt++; $display("FAIL rst_grant: got %0d required 0", grant_id); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b required 0", busy); end
    cmp_cnt++; if (timeout_abort !== 1'b0) begin err_cnt++; $display("FAIL rst_abort: got %b required 0", timeout_abort); end
    cmp_cnt++; if (req_ready !== '0) begin err_cnt++; $display("FAIL rst_ready: got %b required 0", req_ready); end
    RESET_N = 1'b1;
    repeat (2) tick();
    // Start a packet, then pull reset while the strobe is asserted.
    push_byte(0, 8'h11, 1'b0, 1'b0);
    push_byte(0, 8'h12, 1'b1, 1'b0);
    k = 0;
    while (k < 200 && CSN !== 1'b0) begin tick(); k++; end
    cmp_cnt++;
    if (CSN !== 1'b0) begin err_cnt++; $display("FAIL rst_strobe_seen: got CSN %b, required 0 within 200 cycles", CSN); end
    RESET_N = 1'b0;
    #1;
    cmp_cnt++;
    if (CSN !== 1'b1 || WEN !== 1'b1 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL rst_mid_strobe: got CSN %b WEN %b busy %b, required 1 1 0", CSN, WEN, busy);
    end
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    log_q.delete();
    repeat (4) tick();
    RESET_N = 1'b1;
    repeat (12) tick();
    cmp_cnt++;
    if (log_q.size() != 0) begin err_cnt++; $display("FAIL rst_no_strobe: got %0d strobes, required 0", log_q.size()); end
    model_last = NREQ - 1;
    push_pkt(2, 1);
    push_pkt(0, 1);
    push_pkt(3, 1);
    model_drain();
    check_log("rst_first");
  endtask

  task automatic test_packet();
    do_reset();
    push_byte(0, 8'hA1, 1'b0, 1'b1);
    push_byte(0, 8'hA2, 1'b0, 1'b1);
    push_byte(0, 8'hA3, 1'b1, 1'b1);
    model_drain();
    check_log("pkt3");
    cmp_cnt++;
    if (busy !== 1'b0 || grant_id !== 3'd0) begin
      err_cnt++; $display("FAIL pkt3_end: got busy %b grant %0d, required 0 0", busy, grant_id);
    end
  endtask

  task automatic test_rr_order();
    do_reset();
    push_pkt(0, 1); push_pkt(2, 2);
    model_drain(); check_log("rr_02");
    push_pkt(1, 2); push_pkt(2, 1);
    model_drain(); check_log("rr_12");
    push_pkt(0, 1); push_pkt(3, 1);
    model_drain(); check_log("rr_wrap");
  endtask

  task automatic test_txrdy_stall();
    int r0;
    txrdy_en = 1'b0;
    push_pkt(1, 1);
    r0 = ready_cnt;
    repeat (50) tick();
    cmp_cnt++;
    if (ready_cnt != r0 || log_q.size() != 0) begin
      err_cnt++; $display("FAIL stall_hold: got %0d readies %0d strobes, required 0 0", ready_cnt - r0, log_q.size());
    end
    cmp_cnt++;
    if (busy !== 1'b1 || grant_id !== 3'd1) begin
      err_cnt++; $display("FAIL stall_grant: got busy %b grant %0d, required 1 1", busy, grant_id);
    end
    txrdy_en = 1'b1;
    model_drain();
    check_log("stall_send");
  endtask

  task automatic test_late_request();
    int k;
    push_pkt(0, 3);
    model_drain();
    k = 0;
    while (k < 100 && busy !== 1'b1) begin tick(); k++; end
    repeat (2) tick();
    push_pkt(3, 2);
    model_drain();
    check_log("late_req3");
  endtask

  task automatic test_back_to_back();
    push_pkt(2, 2);
    push_pkt(2, 1);
    push_pkt(2, 1);
    model_drain();
    check_log("b2b_sole");
  endtask

  task automatic test_random();
    int n;
    for (int round = 0; round < 4; round++) begin
      n = 0;
      for (int r = 0; r < NREQ; r++) begin
        for (int p = 0; p < $urandom_range(2, 0); p++) begin
          push_pkt(r, $urandom_range(3, 1)); n++;
        end
      end
      if (n == 0) push_pkt($urandom_range(NREQ - 1, 0), 2);
      model_drain();
      check_log("random");
    end
  endtask

  task automatic test_timeout();
    int k, s;
    push_byte(1, 8'h5C, 1'b0, 1'b0);
    k = 0;
    while (k < 200 && log_q.size() < 1) begin tick(); k++; end
    s = (log_q.size() > 0) ? log_q[0].cyc : 0;
    push_byte(2, 8'h62, 1'b1, 1'b0);
    push_byte(0, 8'h60, 1'b1, 1'b0);
`ifdef UART_ARB_TIMEOUT_EN
    k = 0;
    while (k < 100 && abort_cnt == 0) begin tick(); k++; end
    cmp_cnt++;
    if (abort_cnt != 1 || abort_cyc - s != SETTLE + TMO + 1) begin
      err_cnt++; $display("FAIL to_pulse: got %0d pulses at +%0d cycles, required 1 at +%0d", abort_cnt,
                          abort_cyc - s, SETTLE + TMO + 1);
    end
    cmp_cnt++;
    if (abort_busy !== 1'b0) begin err_cnt++; $display("FAIL to_busy: got %b required 0", abort_busy); end
    k = 0;
    while (k < 200 && log_q.size() < 3) begin tick(); k++; end
    cmp_cnt++;
    if (log_q.size() != 3 || log_q[0].req != 1 || log_q[1].req != 2 || log_q[2].req != 0) begin
      err_cnt++; $display("FAIL to_next: got %0d strobes, first grants %0d,%0d, required 3 strobes 1,2,0",
                          log_q.size(), log_q.size() > 0 ? log_q[0].req : -1, log_q.size() > 1 ? log_q[1].req : -1);
    end
`else
    repeat (100) tick();
    cmp_cnt++;
    if (busy !== 1'b1 || grant_id !== 3'd1 || abort_cnt != 0 || log_q.size() != 1) begin
      err_cnt++; $display("FAIL to_held: got busy %b grant %0d aborts %0d strobes %0d, required 1 1 0 1",
                          busy, grant_id, abort_cnt, log_q.size());
    end
    push_byte(1, 8'h5D, 1'b1, 1'b0);
    k = 0;
    while (k < 200 && log_q.size() < 4) begin tick(); k++; end
    cmp_cnt++;
    if (log_q.size() != 4 || log_q[1].data !== 8'h5D || log_q[1].req != 1 || log_q[2].req != 2 || log_q[3].req != 0) begin
      err_cnt++; $display("FAIL to_resume: got %0d strobes, second 0x%02h, required 4 strobes, second 0x5D then req2,req0",
                          log_q.size(), log_q.size() > 1 ? log_q[1].data : 8'h00);
    end
`endif
    repeat (20) tick();
    log_q.delete();
  endtask

  initial begin
    RESET_N   = 1'b0;
    TXRDY     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    txrdy_en  = 1'b1;
    uart_cnt  = 0;
    model_last = NREQ - 1;
    test_reset();
    test_packet();
    test_rr_order();
    test_txrdy_stall();
    test_late_request();
    test_back_to_back();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
